sm_input_filter: RTL
====================

# sm_input_filter

Multi-channel input conditioning block: a per-bit synchroniser of configurable depth, a runtime-programmable stability filter, and registered rise/fall event pulses. It replaces the fixed two-flop metastability filter on board switches and buttons (clock divide select, enable, register address) and conditions slow external lines before they reach the CPU or peripherals. All channels share one clock and one runtime threshold; each channel filters independently.

## Interface
Parameters:
- WIDTH, 1: number of independent channels.
- SYNC_STAGES, 2: synchroniser flops per channel; legal range 2..4.
- CNT_W, 16: width of the stability counter and of `stable_cycles`.
- RESET_VAL, 0: value of every bit of `q` and of every synchroniser flop during reset.

Ports:
- clk  in  1  block clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- d  in  WIDTH  raw asynchronous inputs.
- stable_cycles  in  CNT_W  required stability length N; the values 0 and 1 both mean N=1.
- q  out  WIDTH  filtered level; reset value RESET_VAL.
- rise  out  WIDTH  one-cycle pulse when `q` goes 0->1; reset value 0.
- fall  out  WIDTH  one-cycle pulse when `q` goes 1->0; reset value 0.
- busy  out  WIDTH  channel counter nonzero, meaning a candidate change is pending; reset value 0.

## Operation
- Synchroniser: per bit, a shift chain of SYNC_STAGES flops; s is the last stage.
- Per-channel state: `q` register and a CNT_W-bit counter `cnt`.
- When s == q, `cnt` is cleared to 0 and `q` holds.
- When s != q and cnt+1 >= N, `q` takes s, `cnt` is cleared, and `rise` or `fall` asserts for exactly that cycle.
- When s != q and cnt+1 < N, `cnt` increments.
- Glitch rejection: an excursion of s shorter than N consecutive cycles leaves `q` unchanged and clears `cnt` on return.
- `cnt` never exceeds N-1, so it cannot wrap.
- Threshold lowered mid-count to a value at or below cnt+1: the change commits on the next edge where s != q.
- Threshold raised mid-count: counting continues toward the new N with no restart.
- `rise` and `fall` are mutually exclusive per channel. They are registered and coincide with the cycle the new `q` value is first visible.
- `busy` = (cnt != 0), combinational from the registered counter.
- Reset (rst_n low at an edge): all synchroniser flops and `q` go to RESET_VAL, `cnt` to 0, and `rise`/`fall` to 0. Any pending count is lost.
- After reset, an input already differing from RESET_VAL needs the full latency. A filtered edge never appears during reset.

## Timing
- Number the first rising edge at which the new value is present on `d` as edge 1.
- `q` updates at edge SYNC_STAGES+N and `rise`/`fall` pulse in the same cycle. With defaults and N=1, `q` updates at edge 3.
- Minimum accepted pulse width on `d`: N cycles. Anything shorter is rejected, apart from synchroniser sampling uncertainty of ±1 cycle.
- Throughput: a channel can commit a new change every N cycles. Back-to-back opposite edges with N=1 produce `rise` then `fall` on consecutive cycles.
- `stable_cycles` is sampled every cycle. It is treated as quasi-static and need not be synchronised.

## Structure
- `sm_settings.vh` gains `SM_FILTER_SYNC_STAGES` and `SM_FILTER_STABLE_DEFAULT` (recommended default 16'd1000) for top-level instantiation.
- One sub-module, `sm_filter_channel`, holds the synchroniser chain, `cnt`, `q`, `rise`, `fall` and `busy` for one bit.
- `sm_input_filter` is a generate loop over WIDTH instances sharing `clk`, `rst_n` and `stable_cycles`.

## Test plan
- Reset release, WIDTH=4, RESET_VAL=0, d=4'b0000 → q=0, rise=fall=busy=0 for 100 cycles.
- N=5, d[0] 0->1 held → q[0]=1 and rise[0]=1 for one cycle exactly at edge 7; busy[0] high on edges 3-6.
- N=5, d[1] pulsed high for 4 cycles → q[1] stays 0, no rise/fall, busy[1] returns to 0.
- N=20, raise d[2], then at cnt=10 drop stable_cycles to 3 → q[2] updates on the next edge.
- stable_cycles=0 and =1 give identical traces; d toggles every cycle with N=1 → alternating rise/fall pulses after 2-cycle latency.
- Assert rst_n low while cnt=7 of N=10 → cnt=0, q=RESET_VAL next edge; after release q needs the full SYNC_STAGES+N edges.

Source files
------------

// File: rtl/sm_input_filter_pkg.sv
// sm_input_filter_pkg: shared defaults and the stability threshold test for the input filter.
package sm_input_filter_pkg;

    localparam int          SM_FILTER_SYNC_STAGES    = 2;
    localparam logic [15:0] SM_FILTER_STABLE_DEFAULT = 16'd1000;

    // Threshold of 0 is treated as 1; 33-bit compare so cnt+1 can never wrap.
    function automatic logic threshold_met(input logic [31:0] cnt, input logic [31:0] n);
        return ({1'b0, cnt} + 33'd1) >= {1'b0, (n == 32'd0) ? 32'd1 : n};
    endfunction

endpackage

// File: rtl/sm_filter_channel.sv
// sm_filter_channel: one-bit synchroniser, stability counter and registered rise/fall pulses.
module sm_filter_channel
    import sm_input_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = SM_FILTER_SYNC_STAGES,
    parameter int   CNT_W       = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic [CNT_W-1:0] stable_cycles,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic             busy
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d, rise_q, rise_d, fall_q, fall_d;
    logic                   s, commit;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        commit = (s != q_q) && threshold_met(32'(cnt_q), 32'(stable_cycles));
        q_d    = commit ? s : q_q;
        cnt_d  = (s == q_q || commit) ? '0 : cnt_q + CNT_W'(1);
        rise_d = commit & s;
        fall_d = commit & ~s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/sm_input_filter.sv
// sm_input_filter: WIDTH independent filter channels sharing clock, reset and threshold.
module sm_input_filter
    import sm_input_filter_pkg::*;
#(
    parameter int   WIDTH       = 1,
    parameter int   SYNC_STAGES = SM_FILTER_SYNC_STAGES,
    parameter int   CNT_W       = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [CNT_W-1:0] stable_cycles,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        sm_filter_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_W      (CNT_W),
            .RESET_VAL  (RESET_VAL)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .d            (d[g]),
            .stable_cycles(stable_cycles),
            .q            (q[g]),
            .rise         (rise[g]),
            .fall         (fall[g]),
            .busy         (busy[g])
        );
    end

endmodule
